// File: rtl/sa_pkg.sv
// Shared types and sizing helpers for the systolic MAC array.
package sa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } sa_state_e;

    // Number of registered adder-tree stages needed to reduce n operands
    function automatic int sa_stages(input int n);
        return $clog2(n);
    endfunction

    // Cycles from beat acceptance until the tree sum is registered
    function automatic int sa_latency(input int n);
        return 32'sd1 + sa_stages(n);
    endfunction

    // Operand count entering tree level lv (ceil(n / 2^lv))
    function automatic int sa_ops_at(input int n, input int lv);
        return (n + (32'sd1 <<< lv) - 32'sd1) >>> lv;
    endfunction

endpackage

// File: rtl/sa_adder_tree.sv
// Registered pairwise reduction tree; each level widens by one bit and an
// unpaired operand is carried through its level as a registered pass-through.
module sa_adder_tree
    import sa_pkg::*;
#(
    parameter int N_OPS = 16,
    parameter int OP_W  = 16,
    localparam int STAGES = sa_stages(N_OPS),
    localparam int SUM_W  = OP_W + STAGES
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_OPS*OP_W-1:0]    ops,
    output logic signed [SUM_W-1:0]  sum
);

    for (genvar lv = 0; lv < STAGES; lv++) begin : g_lvl
        localparam int NI = sa_ops_at(N_OPS, lv);
        localparam int NO = sa_ops_at(N_OPS, lv + 1);
        localparam int WI = OP_W + lv;

        logic signed [WI-1:0] d [NI];
        logic signed [WI:0]   q [NO];

        if (lv == 0) begin : g_src
            for (genvar k = 0; k < NI; k++) begin : g_in
                assign d[k] = ops[k*OP_W +: OP_W];
            end
        end else begin : g_src
            assign d = g_lvl[lv-1].q;
        end

        for (genvar j = 0; j < NO; j++) begin : g_node
            logic signed [WI:0] node_r;
            assign q[j] = node_r;

            if (2 * j + 1 < NI) begin : g_add
                // Pairwise sum register
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        node_r <= '0;
                    end else begin
                        node_r <= (WI+1)'(d[2*j]) + (WI+1)'(d[2*j+1]);
                    end
                end
            end else begin : g_pass
                // Odd operand carried to the next level
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        node_r <= '0;
                    end else begin
                        node_r <= (WI+1)'(d[2*j]);
                    end
                end
            end
        end
    end

    assign sum = g_lvl[STAGES-1].q[0];

endmodule

// File: rtl/systolic_array_v2.sv
// Pipelined MAC_NUM-lane dot-product engine with accumulate, shift and saturate.
// Optional build macro SA_ROUND_EN selects round-half-up instead of floor on the shift.
module systolic_array_v2
    import sa_pkg::*;
#(
    parameter int MAC_NUM = 16,
    parameter int BW_ACT  = 8,
    parameter int BW_WET  = 8,
    parameter int BW_ACCU = 32
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_last,
    input  logic signed [MAC_NUM*BW_ACT-1:0]  act_in,
    input  logic signed [MAC_NUM*BW_WET-1:0]  wet_in,
    input  logic [7:0]                        res_shift_num,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [BW_ACT-1:0]          result_out,
    output logic                              busy
);

    localparam int STAGES = sa_stages(MAC_NUM);
    localparam int LAT    = sa_latency(MAC_NUM);
    localparam int PROD_W = BW_ACT + BW_WET;
    localparam int SUM_W  = PROD_W + STAGES;
    localparam logic [7:0] DRAIN_LAST = 8'(LAT);
    localparam logic signed [BW_ACCU:0] SAT_MAX =
        {{(BW_ACCU-BW_ACT+2){1'b0}}, {(BW_ACT-1){1'b1}}};
    localparam logic signed [BW_ACCU:0] SAT_MIN =
        {{(BW_ACCU-BW_ACT+2){1'b1}}, {(BW_ACT-1){1'b0}}};

    sa_state_e                  state_r;
    logic [7:0]                 drain_cnt_r;
    logic [7:0]                 shift_r;
    logic                       in_ready_r;
    logic                       out_valid_r;
    logic                       busy_r;
    logic signed [BW_ACT-1:0]   result_r;
    logic signed [PROD_W-1:0]   prod_r [MAC_NUM];
    logic [MAC_NUM*PROD_W-1:0]  prod_flat_s;
    logic signed [SUM_W-1:0]    tree_sum_s;
    logic signed [BW_ACCU-1:0]  sum_ext_s;
    logic signed [BW_ACCU-1:0]  acc_r;
    logic [LAT-1:0]             vld_pipe_r;
    logic [LAT-1:0]             first_pipe_r;
    logic signed [BW_ACCU:0]    ext_s;
    logic signed [BW_ACCU:0]    bias_s;
    logic signed [BW_ACCU:0]    shifted_s;
    logic signed [BW_ACT-1:0]   sat_s;
    logic                       accept_s;

    assign accept_s   = in_valid & in_ready_r;
    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign result_out = result_r;
    assign busy       = busy_r;

    // Stage 1: per-lane product registers, loaded only on accepted beats
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAC_NUM; i++) prod_r[i] <= '0;
        end else if (accept_s) begin
            for (int i = 0; i < MAC_NUM; i++) begin
                prod_r[i] <= PROD_W'($signed(act_in[i*BW_ACT +: BW_ACT]))
                           * PROD_W'($signed(wet_in[i*BW_WET +: BW_WET]));
            end
        end else begin
            for (int i = 0; i < MAC_NUM; i++) prod_r[i] <= prod_r[i];
        end
    end

    // Flatten the product registers for the tree operand bus
    always_comb begin
        prod_flat_s = '0;
        for (int i = 0; i < MAC_NUM; i++) prod_flat_s[i*PROD_W +: PROD_W] = prod_r[i];
    end

    sa_adder_tree #(
        .N_OPS (MAC_NUM),
        .OP_W  (PROD_W)
    ) u_tree (
        .clk     (clk),
        .reset_n (reset_n),
        .ops     (prod_flat_s),
        .sum     (tree_sum_s)
    );

    // Valid/first-beat tags travel alongside the data so the accumulator knows when to load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe_r   <= '0;
            first_pipe_r <= '0;
        end else begin
            vld_pipe_r   <= {vld_pipe_r[LAT-2:0], accept_s};
            first_pipe_r <= {first_pipe_r[LAT-2:0], accept_s & (state_r == ST_IDLE)};
        end
    end

    assign sum_ext_s = BW_ACCU'(tree_sum_s);

    // Accumulator: load on the first beat, wrap-around add afterwards
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_r <= '0;
        end else if (vld_pipe_r[LAT-1]) begin
            acc_r <= first_pipe_r[LAT-1] ? sum_ext_s : acc_r + sum_ext_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    // Arithmetic shift (optionally rounded) and saturation of the final accumulator
    always_comb begin
        ext_s  = {acc_r[BW_ACCU-1], acc_r};
        bias_s = '0;
`ifdef SA_ROUND_EN
        if ((shift_r != 8'd0) && (32'(shift_r) < BW_ACCU)) begin
            bias_s = {{BW_ACCU{1'b0}}, 1'b1} << (shift_r - 8'd1);
        end else begin
            bias_s = '0;
        end
`endif
        if (32'(shift_r) >= BW_ACCU) begin
            shifted_s = {(BW_ACCU+1){acc_r[BW_ACCU-1]}};
        end else begin
            shifted_s = (ext_s + bias_s) >>> shift_r;
        end
        if (shifted_s > SAT_MAX) begin
            sat_s = {1'b0, {(BW_ACT-1){1'b1}}};
        end else if (shifted_s < SAT_MIN) begin
            sat_s = {1'b1, {(BW_ACT-1){1'b0}}};
        end else begin
            sat_s = shifted_s[BW_ACT-1:0];
        end
    end

    // Control FSM with registered handshake outputs and captured shift
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            drain_cnt_r <= 8'd0;
            shift_r     <= 8'd0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            result_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    in_ready_r  <= 1'b1;
                    drain_cnt_r <= 8'd0;
                    if (accept_s) begin
                        shift_r <= res_shift_num;
                        busy_r  <= 1'b1;
                        if (in_last) begin
                            state_r    <= ST_DRAIN;
                            in_ready_r <= 1'b0;
                        end else begin
                            state_r <= ST_ACCUM;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (accept_s && in_last) begin
                        state_r    <= ST_DRAIN;
                        in_ready_r <= 1'b0;
                    end else begin
                        state_r <= ST_ACCUM;
                    end
                end
                // Wait for the last beat to leave the tree and land in the accumulator
                ST_DRAIN: begin
                    if (drain_cnt_r == DRAIN_LAST) begin
                        state_r     <= ST_OUT;
                        out_valid_r <= 1'b1;
                        result_r    <= sat_s;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + 8'd1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r <= ST_OUT;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_array_v2.sv
// Directed, table-driven bench for systolic_array_v2 with MAC_NUM=4 (L=3).
module tb_systolic_array_v2;

    localparam int MAC_NUM = 4;
    localparam int LAT     = 3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              out_ready = 1'b1;
    logic [31:0]       act_in = 32'd0;
    logic [31:0]       wet_in = 32'd0;
    logic [7:0]        res_shift_num = 8'd0;
    logic              in_ready;
    logic              out_valid;
    logic              busy;
    logic signed [7:0] result_out;

    int tests = 0;
    int fails = 0;

    systolic_array_v2 #(
        .MAC_NUM (MAC_NUM),
        .BW_ACT  (8),
        .BW_WET  (8),
        .BW_ACCU (32)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_last       (in_last),
        .act_in        (act_in),
        .wet_in        (wet_in),
        .res_shift_num (res_shift_num),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result_out    (result_out),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          beats;
        logic [31:0] act;
        logic [31:0] wet;
        logic [7:0]  shift;
        int          exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive_beat(input logic [31:0] a, input logic [31:0] w,
                              input logic last, input logic [7:0] sh);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        act_in = a;
        wet_in = w;
        in_last = last;
        res_shift_num = sh;
        @(posedge clk);
    endtask

    task automatic bubble();
        @(negedge clk);
        in_valid = 1'b0;
        act_in = 32'h7f7f7f7f;
        @(posedge clk);
    endtask

    task automatic wait_result(input string name, input int exp);
        int cyc;
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_lat"}, cyc, LAT + 2);
        check({name, "_res"}, int'(result_out), exp);
    endtask

    task automatic finish_handshake(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        check({name, "_ovalid_drop"}, int'(out_valid), 0);
        check({name, "_iready_back"}, int'(in_ready), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"ones_x_twos",   1, 32'h01010101, 32'h02020202, 8'd0,  8};
        vecs[1]  = '{"max_4beats",    4, 32'h7f7f7f7f, 32'h7f7f7f7f, 8'd0,  127};
        vecs[2]  = '{"neg_sat",       1, 32'h80808080, 32'h7f7f7f7f, 8'd0,  -128};
`ifdef SA_ROUND_EN
        vecs[3]  = '{"pos5_sh1",      1, 32'h00000005, 32'h00000001, 8'd1,  3};
        vecs[4]  = '{"neg5_sh1",      1, 32'h000000fb, 32'h00000001, 8'd1,  -2};
        vecs[11] = '{"neg1_sh3",      1, 32'h000000ff, 32'h00000001, 8'd3,  0};
`else
        vecs[3]  = '{"pos5_sh1",      1, 32'h00000005, 32'h00000001, 8'd1,  2};
        vecs[4]  = '{"neg5_sh1",      1, 32'h000000fb, 32'h00000001, 8'd1,  -3};
        vecs[11] = '{"neg1_sh3",      1, 32'h000000ff, 32'h00000001, 8'd3,  -1};
`endif
        vecs[5]  = '{"neg_bigshift",  1, 32'h000000fb, 32'h00000001, 8'd40, -1};
        vecs[6]  = '{"pos_bigshift",  1, 32'h00000005, 32'h00000001, 8'd40, 0};
        vecs[7]  = '{"mixed_2b_sh2",  2, 32'h04030201, 32'h04fd02ff, 8'd2,  5};
        vecs[8]  = '{"mixed_3b",      3, 32'h04030201, 32'h04fd02ff, 8'd0,  30};
        vecs[9]  = '{"pos_sat",       1, 32'h00000064, 32'h00000003, 8'd0,  127};
        vecs[10] = '{"negsq_sh16",    1, 32'h80808080, 32'h80808080, 8'd16, 1};

        // Reset state
        #12;
        check("rst_in_ready",  int'(in_ready),   0);
        check("rst_out_valid", int'(out_valid),  0);
        check("rst_result",    int'(result_out), 0);
        check("rst_busy",      int'(busy),       0);
        @(negedge clk);
        reset_n = 1'b1;

        // Table-driven vectors with out_ready held high
        for (int i = 0; i < 12; i++) begin
            for (int b = 0; b < vecs[i].beats; b++) begin
                drive_beat(vecs[i].act, vecs[i].wet, (b == vecs[i].beats - 1), vecs[i].shift);
            end
            wait_result(vecs[i].name, vecs[i].exp);
            finish_handshake(vecs[i].name);
        end

        // Output back-pressure: everything frozen while out_ready is low
        out_ready = 1'b0;
        drive_beat(32'h01010101, 32'h02020202, 1'b1, 8'd0);
        wait_result("stall", 8);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_ovalid", int'(out_valid),  1);
            check("stall_result", int'(result_out), 8);
            check("stall_iready", int'(in_ready),   0);
        end
        check("stall_busy", int'(busy), 1);
        finish_handshake("stall_release");
        check("stall_idle_busy", int'(busy), 0);

        // Bubbles between beats must not change the sum (bubble-free run gives 30)
        drive_beat(32'h04030201, 32'h04fd02ff, 1'b0, 8'd0);
        bubble();
        bubble();
        drive_beat(32'h04030201, 32'h04fd02ff, 1'b0, 8'd0);
        bubble();
        drive_beat(32'h04030201, 32'h04fd02ff, 1'b1, 8'd0);
        wait_result("bubbles", 30);
        finish_handshake("bubbles");

        // Shift captured on the first beat only: 30 >>> 1 = 15
        drive_beat(32'h04030201, 32'h04fd02ff, 1'b0, 8'd1);
        drive_beat(32'h04030201, 32'h04fd02ff, 1'b0, 8'd0);
        drive_beat(32'h04030201, 32'h04fd02ff, 1'b1, 8'd7);
        wait_result("shift_capture", 15);
        finish_handshake("shift_capture");

        // Reset mid-vector, then a clean vector
        drive_beat(32'h7f7f7f7f, 32'h7f7f7f7f, 1'b0, 8'd0);
        drive_beat(32'h7f7f7f7f, 32'h7f7f7f7f, 1'b0, 8'd0);
        @(negedge clk);
        in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("midrst_in_ready",  int'(in_ready),   0);
        check("midrst_out_valid", int'(out_valid),  0);
        check("midrst_result",    int'(result_out), 0);
        check("midrst_busy",      int'(busy),       0);
        @(negedge clk);
        reset_n = 1'b1;
        drive_beat(32'h01010101, 32'h02020202, 1'b1, 8'd0);
        wait_result("after_rst", 8);
        finish_handshake("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
